// File: rtl/hsid_pkg.sv
// Shared definitions for the vector-stream sequencer.
//   HSID_DATA_WIDTH      default element width
//   HSID_HSP_BANDS_WIDTH default band-count width
//   OUT_BUF_DEPTH        entries in the result output buffer
//   OUT_BUF_CNT_W        width of the output buffer occupancy count
//   seq_state_e          sequencer FSM states
package hsid_pkg;

    localparam int unsigned HSID_DATA_WIDTH      = 16;
    localparam int unsigned HSID_HSP_BANDS_WIDTH = 8;

    localparam int unsigned OUT_BUF_DEPTH = 2;
    localparam int unsigned OUT_BUF_CNT_W = $clog2(OUT_BUF_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFeed,
        StWait,
        StDone
    } seq_state_e;

endpackage

// File: rtl/vctr_strm_skid.sv
// Small valid/ready output buffer (OUT_BUF_DEPTH entries, FIFO order).
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    write side; in_ready high when an entry is free or one leaves this cycle
//   out_valid/out_data  oldest entry; out_ready pops it
//   count               current occupancy
module vctr_strm_skid import hsid_pkg::*; #(
    parameter int unsigned DATA_WIDTH = HSID_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready,
    output logic [OUT_BUF_CNT_W-1:0] count
);

    localparam int unsigned PtrW = (OUT_BUF_DEPTH > 1) ? $clog2(OUT_BUF_DEPTH) : 1;

    logic [DATA_WIDTH-1:0]    mem_q [OUT_BUF_DEPTH];
    logic [PtrW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [OUT_BUF_CNT_W-1:0] count_q;
    logic                     push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(OUT_BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    // A full buffer may still accept when its head leaves in the same cycle.
    assign in_ready  = (count_q < OUT_BUF_CNT_W'(OUT_BUF_DEPTH)) | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + OUT_BUF_CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - OUT_BUF_CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/vctr_strm_seq.sv
// Vector-stream sequencer: runs a job of job_vctrs vector pairs through an
// external datapath, feeding both source streams jointly and returning results.
//   clk, rst_n                   clock, asynchronous active-low reset
//   job_start/job_vctrs/job_length  job request (length 0 means 2**HSP_BANDS_WIDTH)
//   busy, job_done, vctr_idx     job status
//   s1_*, s2_*                   source streams (valid/ready)
//   m_*                          result stream (valid/ready)
//   dp_*                         datapath control, push and pop ports
module vctr_strm_seq import hsid_pkg::*; #(
    parameter int unsigned DATA_WIDTH      = HSID_DATA_WIDTH,
    parameter int unsigned HSP_BANDS_WIDTH = HSID_HSP_BANDS_WIDTH,
    parameter int unsigned VCTR_CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       job_start,
    input  logic [VCTR_CNT_WIDTH-1:0]  job_vctrs,
    input  logic [HSP_BANDS_WIDTH-1:0] job_length,
    output logic                       busy,
    output logic                       job_done,
    output logic [VCTR_CNT_WIDTH-1:0]  vctr_idx,
    input  logic                       s1_valid,
    input  logic [DATA_WIDTH-1:0]      s1_data,
    output logic                       s1_ready,
    input  logic                       s2_valid,
    input  logic [DATA_WIDTH-1:0]      s2_data,
    output logic                       s2_ready,
    output logic                       m_valid,
    output logic [DATA_WIDTH-1:0]      m_data,
    input  logic                       m_ready,
    output logic                       dp_v1_en,
    output logic [DATA_WIDTH-1:0]      dp_v1,
    output logic                       dp_v2_en,
    output logic [DATA_WIDTH-1:0]      dp_v2,
    input  logic                       dp_v1_full,
    input  logic                       dp_v2_full,
    output logic                       dp_out_en,
    input  logic [DATA_WIDTH-1:0]      dp_out,
    input  logic                       dp_out_empty,
    output logic [HSP_BANDS_WIDTH-1:0] dp_vector_length,
    output logic                       dp_start,
    input  logic                       dp_done,
    input  logic                       dp_idle,
    input  logic                       dp_ready
);

    // One bit wider so a zero length field can count to 2**HSP_BANDS_WIDTH.
    localparam int unsigned CntW = HSP_BANDS_WIDTH + 1;

    seq_state_e                 state_q;
    logic [HSP_BANDS_WIDTH-1:0] length_q;
    logic [CntW-1:0]            len_q;
    logic [VCTR_CNT_WIDTH-1:0]  vctrs_q;
    logic [VCTR_CNT_WIDTH-1:0]  vctr_idx_q;
    logic [CntW-1:0]            in_cnt_q;
    logic [CntW-1:0]            out_cnt_q;
    logic                       inflight_q;

    logic                       in_feed;
    logic                       push;
    logic                       m_pop;
    logic [CntW-1:0]            job_len_dec;
    logic [CntW-1:0]            out_cnt_nxt;
    logic [OUT_BUF_CNT_W-1:0]   buf_count;
    logic [2:0]                 buf_pending;
    logic                       buf_in_ready;
    logic                       unused_sigs;

    always_comb begin
        job_len_dec = {1'b0, job_length};
        if (job_length == '0) begin
            job_len_dec = {1'b1, {HSP_BANDS_WIDTH{1'b0}}};
        end
    end

    assign in_feed = (state_q == StFeed);

    // Joint handshake: an element is taken from both sources or from neither.
    assign push = in_feed & s1_valid & s2_valid & ~dp_v1_full & ~dp_v2_full & (in_cnt_q < len_q);

    assign s1_ready = push;
    assign s2_ready = push;
    assign dp_v1_en = push;
    assign dp_v2_en = push;
    assign dp_v1    = s1_data;
    assign dp_v2    = s2_data;

    assign m_pop = m_valid & m_ready;

    // Pop the datapath only if the word returning next cycle is sure to find a slot.
    assign buf_pending = 3'(buf_count) + 3'(inflight_q) - 3'(m_pop);
    assign dp_out_en   = (state_q != StIdle) & ~dp_out_empty
                       & (buf_pending < 3'(OUT_BUF_DEPTH));

    assign out_cnt_nxt = out_cnt_q + CntW'(in_feed & m_pop);

    assign busy             = (state_q != StIdle);
    assign job_done         = (state_q == StDone);
    assign dp_start         = (state_q == StStart);
    assign vctr_idx         = vctr_idx_q;
    assign dp_vector_length = length_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            length_q   <= '0;
            len_q      <= '0;
            vctrs_q    <= '0;
            vctr_idx_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= dp_out_en;
            if (push) begin
                in_cnt_q <= in_cnt_q + CntW'(1);
            end
            if (in_feed) begin
                out_cnt_q <= out_cnt_nxt;
            end

            unique case (state_q)
                StIdle: begin
                    if (job_start) begin
                        length_q   <= job_length;
                        len_q      <= job_len_dec;
                        vctrs_q    <= job_vctrs;
                        vctr_idx_q <= '0;
                        in_cnt_q   <= '0;
                        out_cnt_q  <= '0;
                        state_q    <= (job_vctrs != '0) ? StStart : StDone;
                    end
                end
                StStart: begin
                    if (dp_ready) begin
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= StFeed;
                    end
                end
                StFeed: begin
                    if (out_cnt_nxt == len_q) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (dp_idle) begin
                        if (vctr_idx_q + VCTR_CNT_WIDTH'(1) == vctrs_q) begin
                            state_q <= StDone;
                        end else begin
                            vctr_idx_q <= vctr_idx_q + VCTR_CNT_WIDTH'(1);
                            state_q    <= StStart;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    vctr_strm_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_data   (dp_out),
        .in_ready  (buf_in_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_ready (m_ready),
        .count     (buf_count)
    );

    // dp_done carries no extra information here; buffer space is guaranteed by dp_out_en.
    assign unused_sigs = dp_done ^ buf_in_ready;

endmodule

// File: tb/tb_vctr_strm_seq.sv
module tb_vctr_strm_seq;

    localparam int DW = 16;
    localparam int BW = 4;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_start;
    logic [VW-1:0] job_vctrs;
    logic [BW-1:0] job_length;
    logic          busy, job_done;
    logic [VW-1:0] vctr_idx;
    logic          s1_valid, s1_ready, s2_valid, s2_ready;
    logic [DW-1:0] s1_data, s2_data;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          dp_v1_en, dp_v2_en, dp_v1_full, dp_v2_full;
    logic [DW-1:0] dp_v1, dp_v2, dp_out;
    logic          dp_out_en, dp_out_empty;
    logic [BW-1:0] dp_vector_length;
    logic          dp_start, dp_done, dp_idle, dp_ready;

    always #5 clk = ~clk;

    vctr_strm_seq #(
        .DATA_WIDTH      (DW),
        .HSP_BANDS_WIDTH (BW),
        .VCTR_CNT_WIDTH  (VW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .job_start        (job_start),
        .job_vctrs        (job_vctrs),
        .job_length       (job_length),
        .busy             (busy),
        .job_done         (job_done),
        .vctr_idx         (vctr_idx),
        .s1_valid         (s1_valid),
        .s1_data          (s1_data),
        .s1_ready         (s1_ready),
        .s2_valid         (s2_valid),
        .s2_data          (s2_data),
        .s2_ready         (s2_ready),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_ready          (m_ready),
        .dp_v1_en         (dp_v1_en),
        .dp_v1            (dp_v1),
        .dp_v2_en         (dp_v2_en),
        .dp_v2            (dp_v2),
        .dp_v1_full       (dp_v1_full),
        .dp_v2_full       (dp_v2_full),
        .dp_out_en        (dp_out_en),
        .dp_out           (dp_out),
        .dp_out_empty     (dp_out_empty),
        .dp_vector_length (dp_vector_length),
        .dp_start         (dp_start),
        .dp_done          (dp_done),
        .dp_idle          (dp_idle),
        .dp_ready         (dp_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source vectors, expected results and a simple element-wise-add datapath model.
    logic [DW-1:0] src1[$];
    logic [DW-1:0] src2[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] dpq[$];
    int  s_idx;

    // Stimulus knobs.
    bit  valid_rand, full_rand, rdy_rand;
    int  mr_mode;      // 0 random, 1 always, 2 toggle
    bit  m_tog;
    int  gap_at, gap_left;
    bit  in_gap;

    // Per-job observations.
    int  n_results, n_done, n_start_hs, vec_push, cur_len;
    logic [BW-1:0] cur_len_code;

    task automatic drive_inputs();
        bit avail;
        avail  = (s_idx < src1.size());
        in_gap = (gap_left > 0) && (s_idx == gap_at);
        if (in_gap) gap_left--;
        s1_valid = avail && (!valid_rand || $urandom_range(0, 3) != 0);
        s2_valid = avail && (!valid_rand || $urandom_range(0, 3) != 0) && !in_gap;
        s1_data  = avail ? src1[s_idx] : DW'($urandom);
        s2_data  = avail ? src2[s_idx] : DW'($urandom);
        case (mr_mode)
            1:       m_ready = 1'b1;
            2:       begin m_ready = m_tog; m_tog = ~m_tog; end
            default: m_ready = ($urandom_range(0, 2) != 0);
        endcase
        dp_v1_full = full_rand && ($urandom_range(0, 4) == 0);
        dp_v2_full = full_rand && ($urandom_range(0, 4) == 0);
        dp_ready   = !rdy_rand || ($urandom_range(0, 1) == 1);
        dp_idle    = (dpq.size() == 0) && (!rdy_rand || ($urandom_range(0, 1) == 1));
    endtask

    // One clock: drive at posedge+1, observe at negedge, advance the environment after posedge.
    task automatic step();
        bit            do_push, do_pop;
        logic [DW-1:0] sum;
        logic [DW-1:0] exp_v;
        drive_inputs();
        @(negedge clk);
        do_push = dp_v1_en;
        do_pop  = dp_out_en;
        sum     = dp_v1 + dp_v2;
        if (dp_v1_en || dp_v2_en || s1_ready || s2_ready) begin
            check_eq("joint_push", {dp_v1_en, dp_v2_en, s1_ready, s2_ready, s1_valid, s2_valid,
                                    !dp_v1_full, !dp_v2_full}, 8'hff);
            check_eq("dp_v1_data", dp_v1, src1[s_idx]);
            check_eq("dp_v2_data", dp_v2, src2[s_idx]);
            check_eq("push_bound", vec_push < cur_len, 1);
            vec_push++;
        end
        if (in_gap) check_eq("s1_ready_in_gap", s1_ready, 0);
        if (dp_out_en) check_eq("pop_nonempty", dp_out_empty, 0);
        if (m_valid && m_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                check_eq("extra_result", m_data, 32'hdead);
            end else begin
                exp_v = exp_q.pop_front();
                check_eq("m_data", m_data, exp_v);
            end
        end
        if (dp_start && dp_ready) begin
            check_eq("vctr_idx", vctr_idx, n_start_hs);
            check_eq("dp_vector_length", dp_vector_length, cur_len_code);
            n_start_hs++;
            vec_push = 0;
        end
        if (job_done) begin
            n_done++;
            check_eq("busy_in_done", busy, 1);
        end
        @(posedge clk);
        #1;
        if (do_pop && dpq.size() > 0) dp_out = dpq.pop_front();
        if (do_push) begin
            dpq.push_back(sum);
            s_idx++;
        end
        dp_out_empty = (dpq.size() == 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {busy, job_done, m_valid, dp_start, dp_v1_en, dp_v2_en, dp_out_en,
                       s1_ready, s2_ready}, 9'h0);
        check_eq({tag, "_vctr_idx"}, vctr_idx, 0);
    endtask

    task automatic run_job(input int len_code, input int vctrs, input int pattern,
                           input bit stray, input int rst_after, input int max_cyc);
        int            len, cyc;
        logic [DW-1:0] a, b, s;
        len = (len_code == 0) ? (1 << BW) : len_code;
        src1.delete(); src2.delete(); exp_q.delete();
        for (int v = 0; v < vctrs; v++) begin
            for (int k = 0; k < len; k++) begin
                case (pattern)
                    1:       begin a = DW'(k + 1); b = DW'(k + 5); end
                    2:       begin a = DW'(k);     b = DW'(2 * k); end
                    default: begin a = DW'($urandom); b = DW'($urandom); end
                endcase
                s = a + b;
                src1.push_back(a);
                src2.push_back(b);
                exp_q.push_back(s);
            end
        end
        s_idx = 0; n_results = 0; n_done = 0; n_start_hs = 0; vec_push = 0;
        cur_len = len;
        cur_len_code = BW'(len_code);
        job_start  = 1'b1;
        job_vctrs  = VW'(vctrs);
        job_length = BW'(len_code);
        step();
        cyc = 1;
        while (n_done == 0 && cyc < 4000) begin
            if (stray && cyc == 5) begin
                job_start = 1'b1; job_vctrs = 8'd5; job_length = 4'd3;
            end else begin
                job_start = 1'b0;
            end
            step();
            cyc++;
            if (rst_after >= 0 && n_results == rst_after) begin
                job_start = 1'b0;
                rst_n = 1'b0;
                dpq.delete(); exp_q.delete(); src1.delete(); src2.delete();
                s_idx = 0;
                dp_out_empty = 1'b1;
                s1_valid = 1'b1; s2_valid = 1'b1;
                @(negedge clk);
                check_idle_outputs("mid_job_reset");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        job_start = 1'b0;
        check_eq("job_done_seen", n_done, 1);
        if (max_cyc > 0) check_eq("job_cycles_in_bound", cyc <= max_cyc, 1);
        check_eq("result_count", n_results, vctrs * len);
        check_eq("results_left", exp_q.size(), 0);
        check_eq("dp_start_count", n_start_hs, vctrs);
        repeat (3) step();
        check_eq("single_job_done", n_done, 1);
        check_eq("busy_after_done", busy, 0);
    endtask

    task automatic set_modes(input bit vr, input bit fr, input bit rr, input int mr);
        valid_rand = vr; full_rand = fr; rdy_rand = rr; mr_mode = mr;
        m_tog = 1'b1; gap_left = 0; gap_at = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        job_start = 1'b0; job_vctrs = '0; job_length = '0;
        s1_valid = 1'b1; s2_valid = 1'b1; s1_data = '0; s2_data = '0;
        m_ready = 1'b1; dp_v1_full = 1'b0; dp_v2_full = 1'b0;
        dp_out = '0; dp_out_empty = 1'b1; dp_done = 1'b0; dp_idle = 1'b1; dp_ready = 1'b1;
        s_idx = 0; cur_len = 0; cur_len_code = '0; in_gap = 1'b0;
        set_modes(0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single vector, fixed data: 6, 8, 10, 12.
        set_modes(0, 0, 0, 1);
        run_job(4, 1, 1, 0, -1, 0);
        // Three vectors plus an ignored request while busy.
        run_job(4, 3, 2, 1, -1, 0);
        // Back-pressure toggling every cycle.
        set_modes(0, 0, 0, 2);
        run_job(4, 3, 2, 0, -1, 0);
        // s2 stalls three cycles mid-vector.
        set_modes(0, 0, 0, 1);
        gap_at = 2; gap_left = 3;
        run_job(4, 1, 1, 0, -1, 0);
        // Empty job completes straight away.
        run_job(4, 0, 0, 0, -1, 2);
        // Zero length field means 16 bands; sustained one element per cycle.
        set_modes(0, 0, 0, 1);
        run_job(0, 1, 0, 0, -1, 16 + 9);
        // Randomized jobs with random stalls everywhere.
        for (int i = 0; i < 6; i++) begin
            set_modes(1, 1, 1, 0);
            run_job($urandom_range(0, 15), $urandom_range(1, 4), 0, 0, -1, 0);
        end
        // Reset after two results, then a clean job.
        set_modes(0, 0, 0, 1);
        run_job(4, 1, 1, 0, 2, 0);
        run_job(4, 1, 1, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
